// File: rtl/iboot_memif_responder_pkg.sv
// Shared types for the boot-loader memory-interface responder.
// Holds the FSM state encoding and the write-buffer entry layout.
package iboot_memif_responder_pkg;

  localparam int DQM_W   = 4;
  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = DQM_W + ADDR_W + DATA_W;

  typedef enum logic {
    BOOTING = 1'b0,
    DONE    = 1'b1
  } boot_state_t;

  typedef struct packed {
    logic [DQM_W-1:0]  dqm;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/iboot_memif_fifo.sv
// Synchronous FIFO with occupancy count; storage is not reset.
// Pushes when full and pops when empty are ignored.
module iboot_memif_fifo #(
  parameter int P_WIDTH   = 61,
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iRESET_SYNC,
  input  logic                 i_push,
  input  logic [P_WIDTH-1:0]   i_data,
  input  logic                 i_pop,
  output logic [P_WIDTH-1:0]   o_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [P_DEPTH_N:0]   o_count
);

  logic [P_WIDTH-1:0]   r_mem [P_DEPTH];
  logic [P_DEPTH_N-1:0] r_wptr;
  logic [P_DEPTH_N-1:0] r_rptr;
  logic [P_DEPTH_N:0]   r_count;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_count == (P_DEPTH_N+1)'(P_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (iRESET_SYNC) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{P_DEPTH_N{1'b0}}, w_push} - {{P_DEPTH_N{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/iboot_memif_responder.sv
// Accepts boot-loader write requests, buffers them and forwards them to memory.
// Tracks word count, address-sequence and read-request errors, and boot completion.
module iboot_memif_responder
  import iboot_memif_responder_pkg::*;
#(
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              iRESET_SYNC,
  input  logic              iIBOOT_VALID,
  input  logic              iIBOOT_MEMIF_REQ_VALID,
  input  logic              iIBOOT_MEMIF_REQ_DQM0,
  input  logic              iIBOOT_MEMIF_REQ_DQM1,
  input  logic              iIBOOT_MEMIF_REQ_DQM2,
  input  logic              iIBOOT_MEMIF_REQ_DQM3,
  input  logic              iIBOOT_MEMIF_REQ_RW,
  input  logic [24:0]       iIBOOT_MEMIF_REQ_ADDR,
  input  logic [31:0]       iIBOOT_MEMIF_REQ_DATA,
  output logic              oIBOOT_MEMIF_REQ_LOCK,
  output logic              oMEM_REQ_VALID,
  output logic [3:0]        oMEM_REQ_DQM,
  output logic              oMEM_REQ_RW,
  output logic [24:0]       oMEM_REQ_ADDR,
  output logic [31:0]       oMEM_REQ_DATA,
  input  logic              iMEM_REQ_LOCK,
  output logic              oBOOT_DONE,
  output logic [21:0]       oWORD_COUNT,
  output logic              oERR_SEQ,
  output logic              oERR_RW
);

  boot_state_t        r_state;
  boot_state_t        w_state_next;
  logic               r_iboot_valid;
  logic [21:0]        r_word_count;
  logic [ADDR_W-1:0]  r_exp_addr;
  logic               r_err_seq;
  logic               r_err_rw;
  logic               w_full;
  logic               w_empty;
  logic [P_DEPTH_N:0] w_count;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  entry_t             w_in_entry;
  entry_t             w_head;

  assign w_in_entry.dqm  = {iIBOOT_MEMIF_REQ_DQM3, iIBOOT_MEMIF_REQ_DQM2,
                            iIBOOT_MEMIF_REQ_DQM1, iIBOOT_MEMIF_REQ_DQM0};
  assign w_in_entry.addr = iIBOOT_MEMIF_REQ_ADDR;
  assign w_in_entry.data = iIBOOT_MEMIF_REQ_DATA;

  assign oIBOOT_MEMIF_REQ_LOCK = w_full | iRESET_SYNC;
  assign w_accept = iIBOOT_MEMIF_REQ_VALID & ~oIBOOT_MEMIF_REQ_LOCK;
  assign w_push   = w_accept & iIBOOT_MEMIF_REQ_RW;
  // Sync reset masks the head so buffered words are dropped, never emitted.
  assign w_pop    = ~w_empty & ~iMEM_REQ_LOCK & ~iRESET_SYNC;

  iboot_memif_fifo #(
    .P_WIDTH   (ENTRY_W),
    .P_DEPTH   (P_DEPTH),
    .P_DEPTH_N (P_DEPTH_N)
  ) u_fifo (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .i_push      (w_push),
    .i_data      (w_in_entry),
    .i_pop       (w_pop),
    .o_data      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign oMEM_REQ_VALID = w_pop;
  assign oMEM_REQ_DQM   = w_head.dqm;
  assign oMEM_REQ_RW    = 1'b1;
  assign oMEM_REQ_ADDR  = w_head.addr;
  assign oMEM_REQ_DATA  = w_head.data;
  assign oBOOT_DONE     = (r_state == DONE);
  assign oWORD_COUNT    = r_word_count;
  assign oERR_SEQ       = r_err_seq;
  assign oERR_RW        = r_err_rw;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state       <= BOOTING;
      r_iboot_valid <= 1'b1;
      r_word_count  <= '0;
      r_exp_addr    <= '0;
      r_err_seq     <= 1'b0;
      r_err_rw      <= 1'b0;
    end else if (iRESET_SYNC) begin
      r_state       <= BOOTING;
      r_iboot_valid <= 1'b1;
      r_word_count  <= '0;
      r_exp_addr    <= '0;
      r_err_seq     <= 1'b0;
      r_err_rw      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_iboot_valid <= iIBOOT_VALID;
      if (w_push) begin
        r_word_count <= r_word_count + 22'd1;
        r_exp_addr   <= r_exp_addr + 25'd1;
        if (iIBOOT_MEMIF_REQ_ADDR != r_exp_addr) r_err_seq <= 1'b1;
      end
      if (w_accept && !iIBOOT_MEMIF_REQ_RW) r_err_rw <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOTING: if (!r_iboot_valid && (w_count == '0) && !w_push) w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = BOOTING;
    endcase
  end

endmodule

// File: tb/tb_iboot_memif_responder.sv
// Directed bench for iboot_memif_responder: streaming, backpressure, errors,
// boot completion and synchronous reset, with emitted words captured by a monitor.
module tb_iboot_memif_responder;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iRESET_SYNC = 1'b0;
  logic        iIBOOT_VALID = 1'b1;
  logic        iIBOOT_MEMIF_REQ_VALID = 1'b0;
  logic        iIBOOT_MEMIF_REQ_DQM0 = 1'b0;
  logic        iIBOOT_MEMIF_REQ_DQM1 = 1'b0;
  logic        iIBOOT_MEMIF_REQ_DQM2 = 1'b0;
  logic        iIBOOT_MEMIF_REQ_DQM3 = 1'b0;
  logic        iIBOOT_MEMIF_REQ_RW = 1'b0;
  logic [24:0] iIBOOT_MEMIF_REQ_ADDR = '0;
  logic [31:0] iIBOOT_MEMIF_REQ_DATA = '0;
  logic        oIBOOT_MEMIF_REQ_LOCK;
  logic        oMEM_REQ_VALID;
  logic [3:0]  oMEM_REQ_DQM;
  logic        oMEM_REQ_RW;
  logic [24:0] oMEM_REQ_ADDR;
  logic [31:0] oMEM_REQ_DATA;
  logic        iMEM_REQ_LOCK = 1'b0;
  logic        oBOOT_DONE;
  logic [21:0] oWORD_COUNT;
  logic        oERR_SEQ;
  logic        oERR_RW;

  int n_vec = 0;
  int n_err = 0;
  logic [61:0] cap [$];

  always #5 iCLOCK = ~iCLOCK;

  iboot_memif_responder #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iIBOOT_VALID(iIBOOT_VALID), .iIBOOT_MEMIF_REQ_VALID(iIBOOT_MEMIF_REQ_VALID),
    .iIBOOT_MEMIF_REQ_DQM0(iIBOOT_MEMIF_REQ_DQM0), .iIBOOT_MEMIF_REQ_DQM1(iIBOOT_MEMIF_REQ_DQM1),
    .iIBOOT_MEMIF_REQ_DQM2(iIBOOT_MEMIF_REQ_DQM2), .iIBOOT_MEMIF_REQ_DQM3(iIBOOT_MEMIF_REQ_DQM3),
    .iIBOOT_MEMIF_REQ_RW(iIBOOT_MEMIF_REQ_RW), .iIBOOT_MEMIF_REQ_ADDR(iIBOOT_MEMIF_REQ_ADDR),
    .iIBOOT_MEMIF_REQ_DATA(iIBOOT_MEMIF_REQ_DATA), .oIBOOT_MEMIF_REQ_LOCK(oIBOOT_MEMIF_REQ_LOCK),
    .oMEM_REQ_VALID(oMEM_REQ_VALID), .oMEM_REQ_DQM(oMEM_REQ_DQM), .oMEM_REQ_RW(oMEM_REQ_RW),
    .oMEM_REQ_ADDR(oMEM_REQ_ADDR), .oMEM_REQ_DATA(oMEM_REQ_DATA), .iMEM_REQ_LOCK(iMEM_REQ_LOCK),
    .oBOOT_DONE(oBOOT_DONE), .oWORD_COUNT(oWORD_COUNT), .oERR_SEQ(oERR_SEQ), .oERR_RW(oERR_RW)
  );

  // Downstream monitor: one entry {rw, dqm, addr, data} per emitted word.
  always @(posedge iCLOCK)
    if (oMEM_REQ_VALID) cap.push_back({oMEM_REQ_RW, oMEM_REQ_DQM, oMEM_REQ_ADDR, oMEM_REQ_DATA});

  task automatic apply_reset();
    @(negedge iCLOCK);
    inRESET = 1'b0;
    iRESET_SYNC = 1'b0;
    iIBOOT_VALID = 1'b1;
    iIBOOT_MEMIF_REQ_VALID = 1'b0;
    iIBOOT_MEMIF_REQ_RW = 1'b0;
    {iIBOOT_MEMIF_REQ_DQM3, iIBOOT_MEMIF_REQ_DQM2, iIBOOT_MEMIF_REQ_DQM1, iIBOOT_MEMIF_REQ_DQM0} = 4'h0;
    iMEM_REQ_LOCK = 1'b0;
    repeat (2) @(negedge iCLOCK);
    inRESET = 1'b1;
    cap.delete();
  endtask

  task automatic tick_req(input logic rw, input logic [24:0] addr, input logic [31:0] data,
                          input logic [3:0] dqm);
    @(negedge iCLOCK);
    iIBOOT_MEMIF_REQ_VALID = 1'b1;
    iIBOOT_MEMIF_REQ_RW = rw;
    iIBOOT_MEMIF_REQ_ADDR = addr;
    iIBOOT_MEMIF_REQ_DATA = data;
    {iIBOOT_MEMIF_REQ_DQM3, iIBOOT_MEMIF_REQ_DQM2, iIBOOT_MEMIF_REQ_DQM1, iIBOOT_MEMIF_REQ_DQM0} = dqm;
  endtask

  task automatic idle(input int n);
    @(negedge iCLOCK);
    iIBOOT_MEMIF_REQ_VALID = 1'b0;
    repeat (n - 1) @(negedge iCLOCK);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_vec++;
    if ({oIBOOT_MEMIF_REQ_LOCK, oMEM_REQ_VALID, oBOOT_DONE, oERR_SEQ, oERR_RW} !== 5'b0 || oWORD_COUNT !== 22'd0) begin
      n_err++;
      $display("FAIL reset_state: lock/valid/done/seq/rw=%b wc=%0d, required 00000 wc=0",
               {oIBOOT_MEMIF_REQ_LOCK, oMEM_REQ_VALID, oBOOT_DONE, oERR_SEQ, oERR_RW}, oWORD_COUNT);
    end
  endtask

  task automatic test_stream();
    logic [61:0] exp;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      tick_req(1'b1, 25'(i), 32'hA000_0000 + 32'(i), 4'h0);
      #1;
      if (i == 0) begin
        n_vec++;
        if (oMEM_REQ_VALID !== 1'b0) begin
          n_err++; $display("FAIL stream_latency0: valid=%b required 0", oMEM_REQ_VALID);
        end
      end
      if (i == 1) begin
        n_vec++;
        if (oMEM_REQ_VALID !== 1'b1 || oMEM_REQ_ADDR !== 25'd0) begin
          n_err++; $display("FAIL stream_latency1: valid=%b addr=%0d required 1/0", oMEM_REQ_VALID, oMEM_REQ_ADDR);
        end
      end
    end
    idle(4);
    n_vec++;
    if (cap.size() != 8) begin
      n_err++; $display("FAIL stream_count: emitted %0d required 8", cap.size());
    end
    for (int i = 0; i < 8 && i < cap.size(); i++) begin
      exp = {1'b1, 4'h0, 25'(i), 32'hA000_0000 + 32'(i)};
      n_vec++;
      if (cap[i] !== exp) begin
        n_err++; $display("FAIL stream_word%0d: got %h required %h", i, cap[i], exp);
      end
    end
    n_vec++;
    if (oWORD_COUNT !== 22'd8 || oERR_SEQ !== 1'b0 || oERR_RW !== 1'b0) begin
      n_err++; $display("FAIL stream_status: wc=%0d seq=%b rw=%b required 8/0/0", oWORD_COUNT, oERR_SEQ, oERR_RW);
    end
  endtask

  task automatic test_backpressure();
    int nxt = 0;
    int cyc = 0;
    apply_reset();
    iMEM_REQ_LOCK = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick_req(1'b1, 25'(nxt), 32'h5000_0000 + 32'(nxt), 4'h0);
      #1;
      n_vec++;
      if (oIBOOT_MEMIF_REQ_LOCK !== (c >= 4)) begin
        n_err++; $display("FAIL bp_lock_c%0d: lock=%b required %b", c, oIBOOT_MEMIF_REQ_LOCK, (c >= 4));
      end
      if (!oIBOOT_MEMIF_REQ_LOCK) nxt++;
    end
    n_vec++;
    if (oWORD_COUNT !== 22'd4 || cap.size() != 0) begin
      n_err++; $display("FAIL bp_held: wc=%0d emitted=%0d required 4/0", oWORD_COUNT, cap.size());
    end
    // Release downstream while still offering words: pushes and pops overlap.
    iMEM_REQ_LOCK = 1'b0;
    while (nxt < 8 && cyc < 20) begin
      tick_req(1'b1, 25'(nxt), 32'h5000_0000 + 32'(nxt), 4'h0);
      #1;
      if (!oIBOOT_MEMIF_REQ_LOCK) nxt++;
      cyc++;
    end
    idle(6);
    n_vec++;
    if (cap.size() != 8 || oWORD_COUNT !== 22'd8) begin
      n_err++; $display("FAIL bp_drain_count: emitted=%0d wc=%0d required 8/8", cap.size(), oWORD_COUNT);
    end
    for (int i = 0; i < 8 && i < cap.size(); i++) begin
      n_vec++;
      if (cap[i][56:32] !== 25'(i) || cap[i][31:0] !== 32'h5000_0000 + 32'(i)) begin
        n_err++; $display("FAIL bp_order%0d: addr=%0d data=%h required %0d/%h",
                          i, cap[i][56:32], cap[i][31:0], i, 32'h5000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_seq_err();
    logic [24:0] addrs [3];
    addrs[0] = 25'd0; addrs[1] = 25'd1; addrs[2] = 25'd3;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      tick_req(1'b1, addrs[i], 32'hC0DE_0000 + 32'(i), (i == 2) ? 4'b1010 : 4'h0);
      @(negedge iCLOCK);
      iIBOOT_MEMIF_REQ_VALID = 1'b0;
      #1;
      n_vec++;
      if (oERR_SEQ !== (i == 2)) begin
        n_err++; $display("FAIL seq_flag%0d: seq=%b required %b", i, oERR_SEQ, (i == 2));
      end
    end
    idle(3);
    n_vec++;
    if (cap.size() != 3) begin
      n_err++; $display("FAIL seq_emitted: %0d required 3", cap.size());
    end else begin
      n_vec++;
      if (cap[2][60:57] !== 4'b1010 || cap[2][56:32] !== 25'd3 || cap[1][56:32] !== 25'd1) begin
        n_err++; $display("FAIL seq_word3: dqm=%b addr=%0d required 1010/3", cap[2][60:57], cap[2][56:32]);
      end
    end
  endtask

  task automatic test_rw_err();
    apply_reset();
    tick_req(1'b1, 25'd0, 32'h1111_1111, 4'h0);
    tick_req(1'b0, 25'd1, 32'h2222_2222, 4'h0);
    idle(3);
    n_vec++;
    if (oERR_RW !== 1'b1 || oWORD_COUNT !== 22'd1 || cap.size() != 1) begin
      n_err++; $display("FAIL rw_flag: rw=%b wc=%0d emitted=%0d required 1/1/1", oERR_RW, oWORD_COUNT, cap.size());
    end
    tick_req(1'b1, 25'd1, 32'h3333_3333, 4'h0);
    idle(3);
    n_vec++;
    if (oERR_SEQ !== 1'b0 || oWORD_COUNT !== 22'd2 || cap.size() != 2) begin
      n_err++; $display("FAIL rw_expaddr: seq=%b wc=%0d emitted=%0d required 0/2/2", oERR_SEQ, oWORD_COUNT, cap.size());
    end
  endtask

  task automatic test_boot_done();
    logic exp_done [4];
    exp_done[0] = 1'b0; exp_done[1] = 1'b0; exp_done[2] = 1'b0; exp_done[3] = 1'b1;
    apply_reset();
    iMEM_REQ_LOCK = 1'b1;
    for (int i = 0; i < 3; i++) tick_req(1'b1, 25'(i), 32'hB000_0000 + 32'(i), 4'h0);
    @(negedge iCLOCK);
    iIBOOT_MEMIF_REQ_VALID = 1'b0;
    iIBOOT_VALID = 1'b0;
    repeat (3) @(negedge iCLOCK);
    #1;
    n_vec++;
    if (oBOOT_DONE !== 1'b0) begin
      n_err++; $display("FAIL boot_held: done=%b required 0", oBOOT_DONE);
    end
    iMEM_REQ_LOCK = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge iCLOCK);
      #1;
      n_vec++;
      if (oBOOT_DONE !== exp_done[k]) begin
        n_err++; $display("FAIL boot_drain%0d: done=%b required %b", k, oBOOT_DONE, exp_done[k]);
      end
    end
    tick_req(1'b1, 25'd3, 32'hB000_0003, 4'h0);
    idle(3);
    n_vec++;
    if (oBOOT_DONE !== 1'b1 || oWORD_COUNT !== 22'd4 || cap.size() != 4 || oERR_SEQ !== 1'b0) begin
      n_err++; $display("FAIL boot_after_done: done=%b wc=%0d emitted=%0d seq=%b required 1/4/4/0",
                        oBOOT_DONE, oWORD_COUNT, cap.size(), oERR_SEQ);
    end
  endtask

  task automatic test_sync_reset();
    apply_reset();
    iMEM_REQ_LOCK = 1'b1;
    tick_req(1'b0, 25'd9, 32'h0, 4'h0);
    tick_req(1'b1, 25'd0, 32'hD000_0000, 4'h0);
    tick_req(1'b1, 25'd1, 32'hD000_0001, 4'h0);
    idle(1);
    #1;
    n_vec++;
    if (oERR_RW !== 1'b1 || oWORD_COUNT !== 22'd2) begin
      n_err++; $display("FAIL srst_pre: rw=%b wc=%0d required 1/2", oERR_RW, oWORD_COUNT);
    end
    tick_req(1'b1, 25'd2, 32'hD000_0002, 4'h0);
    iRESET_SYNC = 1'b1;
    iMEM_REQ_LOCK = 1'b0;
    #1;
    n_vec++;
    if (oIBOOT_MEMIF_REQ_LOCK !== 1'b1 || oMEM_REQ_VALID !== 1'b0) begin
      n_err++; $display("FAIL srst_pulse: lock=%b valid=%b required 1/0", oIBOOT_MEMIF_REQ_LOCK, oMEM_REQ_VALID);
    end
    @(negedge iCLOCK);
    iRESET_SYNC = 1'b0;
    iIBOOT_MEMIF_REQ_VALID = 1'b0;
    #1;
    n_vec++;
    if (oWORD_COUNT !== 22'd0 || oERR_RW !== 1'b0 || oERR_SEQ !== 1'b0 || oMEM_REQ_VALID !== 1'b0 ||
        oBOOT_DONE !== 1'b0 || oIBOOT_MEMIF_REQ_LOCK !== 1'b0) begin
      n_err++; $display("FAIL srst_after: wc=%0d rw=%b seq=%b valid=%b done=%b lock=%b required 0/0/0/0/0/0",
                        oWORD_COUNT, oERR_RW, oERR_SEQ, oMEM_REQ_VALID, oBOOT_DONE, oIBOOT_MEMIF_REQ_LOCK);
    end
    idle(3);
    n_vec++;
    if (cap.size() != 0) begin
      n_err++; $display("FAIL srst_emitted: %0d required 0", cap.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_seq_err();
    test_rw_err();
    test_boot_done();
    test_sync_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iboot_memif_responder.md
IBOOT_MEMIF_RESPONDER -- requirements
Module: iboot_memif_responder

Interface
REQ-001 SHALL have parameter P_DEPTH, default 4: write-buffer depth in words, a power of 2 and at least 2.
REQ-002 SHALL have parameter P_DEPTH_N, default 2: log2(P_DEPTH).
REQ-003 SHALL have: iCLOCK  in  1  system clock.
REQ-004 SHALL have: inRESET  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have: iRESET_SYNC  in  1  synchronous reset, active-high.
REQ-006 SHALL have: iIBOOT_VALID  in  1  boot loader active; low = loader finished.
REQ-007 SHALL have: iIBOOT_MEMIF_REQ_VALID  in  1  request strobe.
REQ-008 SHALL have: iIBOOT_MEMIF_REQ_DQM0..3  in  1 each  byte masks; 1 = lane masked.
REQ-009 SHALL have: iIBOOT_MEMIF_REQ_RW  in  1  0 = read, 1 = write.
REQ-010 SHALL have: iIBOOT_MEMIF_REQ_ADDR  in  25  word address.
REQ-011 SHALL have: iIBOOT_MEMIF_REQ_DATA  in  32  write data, byte 0 in [7:0].
REQ-012 SHALL have: oIBOOT_MEMIF_REQ_LOCK  out  1  responder cannot accept.
REQ-013 SHALL have: oMEM_REQ_VALID  out  1, oMEM_REQ_DQM  out  4, oMEM_REQ_RW  out  1, oMEM_REQ_ADDR  out  25, oMEM_REQ_DATA  out  32  downstream write port.
REQ-014 SHALL have: iMEM_REQ_LOCK  in  1  downstream busy.
REQ-015 SHALL have: oBOOT_DONE  out  1, oWORD_COUNT  out  22, oERR_SEQ  out  1, oERR_RW  out  1  status outputs.

Function
REQ-016 SHALL drive oIBOOT_MEMIF_REQ_LOCK combinationally high when the buffer holds P_DEPTH words or iRESET_SYNC=1; otherwise low.
REQ-017 SHALL accept a request in any cycle with iIBOOT_MEMIF_REQ_VALID=1 and oIBOOT_MEMIF_REQ_LOCK=0; SHALL ignore VALID while LOCK=1.
REQ-018 On accepting a write (RW=1), SHALL push {DQM3..0, ADDR, DATA} into the FIFO and increment oWORD_COUNT by 1; oWORD_COUNT SHALL wrap from 22'h3FFFFF to 0.
REQ-019 On accepting a read (RW=0), SHALL discard the request without pushing or counting, and SHALL set oERR_RW sticky.
REQ-020 SHALL keep an expected-address register that starts at 0 and increments on each accepted write; an accepted write with ADDR different from it SHALL set oERR_SEQ sticky, and the word SHALL still be buffered.
REQ-021 SHALL drive oMEM_REQ_VALID = FIFO non-empty AND NOT iMEM_REQ_LOCK, with oMEM_REQ_* showing the head entry and oMEM_REQ_RW=1 constant.
REQ-022 SHALL pop the head in each cycle in which oMEM_REQ_VALID=1.
REQ-023 Latency SHALL be: a word accepted in cycle N can appear on oMEM_REQ_VALID no earlier than cycle N+1.
REQ-024 With a simultaneous push and pop, occupancy SHALL be unchanged and order SHALL be preserved; push is impossible when full (REQ-016).
REQ-025 SHALL register iIBOOT_VALID and use a two-state FSM:
- BOOTING -> DONE when the registered iIBOOT_VALID=0 AND the FIFO is empty AND no push occurs this cycle.
- DONE is terminal until reset.
REQ-026 oBOOT_DONE SHALL equal 1 exactly in state DONE.
REQ-027 In DONE, accepted requests SHALL still be processed per REQ-018..020, with no state change.
REQ-028 Pointers SHALL be P_DEPTH_N bits wrapping modulo P_DEPTH; occupancy SHALL be P_DEPTH_N+1 bits.

Reset
REQ-029 inRESET low (async) or iRESET_SYNC high (sync) SHALL set:
- FIFO empty;
- oWORD_COUNT=0, expected address=0;
- oERR_SEQ=0, oERR_RW=0;
- state BOOTING, oBOOT_DONE=0, oMEM_REQ_VALID=0.
REQ-030 Reset mid-transfer SHALL discard buffered words without emitting them.
REQ-031 FIFO data storage SHALL NOT require reset.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (BOOTING=1'b0, DONE=1'b1) and the FIFO entry field widths (4+25+32=61).
REQ-033 The FIFO SHALL be one sub-module, iboot_memif_fifo (parameterised by width and depth, push/pop/full/empty/count).

Verification
REQ-034 Reset, then 8 writes at ADDR 0..7 with DATA=32'hA0000000+addr, iMEM_REQ_LOCK=0 -> 8 downstream writes in order, DQM=4'h0, oWORD_COUNT=8, no errors.
REQ-035 iMEM_REQ_LOCK=1, VALID held high -> LOCK rises after 4 accepts; release iMEM_REQ_LOCK -> all words drain in order, none lost or duplicated.
REQ-036 Writes at ADDR 0,1,3 -> oERR_SEQ=1 after the third accept; all 3 words are still emitted.
REQ-037 One RW=0 request -> oERR_RW=1, nothing emitted, oWORD_COUNT unchanged.
REQ-038 iIBOOT_VALID falls while 3 words are buffered under iMEM_REQ_LOCK=1 -> oBOOT_DONE stays 0 until the last pop, then 1.
REQ-039 iRESET_SYNC pulse while 2 words are buffered -> no emission, counters 0, LOCK high during the pulse, oBOOT_DONE=0.
